// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encodings and counter sizing.
package seq_multiplier_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Iteration counter width: enough to hold WB-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done handshake and operand/result bundle for seq_multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WA = 4,
  parameter int unsigned WB = 4
);
  logic                 start;
  logic [WA-1:0]        a;
  logic [WB-1:0]        b;
  logic                 busy;
  logic                 done;
  logic [WA+WB-1:0]     out;

  modport master (output start, a, b, input busy, done, out);
  modport slave  (input start, a, b, output busy, done, out);
endinterface

// File: rtl/seq_multiplier_addsub_n.sv
// W-bit ripple-carry adder/subtractor; sub inverts y and injects the carry-in.
module addsub_n #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] y_eff;
  logic         carry;

  // One full-adder cell per bit, carry rippling LSB to MSB.
  always_comb begin
    y_eff = y ^ {W{sub}};
    carry = sub;
    s     = '0;
    for (int i = 0; i < int'(W); i++) begin
      s[i]  = x[i] ^ y_eff[i] ^ carry;
      carry = (x[i] & y_eff[i]) | (carry & (x[i] ^ y_eff[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WA x WB shift-add multiplier, one partial product per clock.
// Define SIGNED_MULT_EN for a two's-complement build; ports are identical either way.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WA = 4,
  parameter int unsigned WB = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_multiplier_if.slave   bus
);

  localparam int unsigned PW = WA + WB;
  localparam int unsigned AW = WA + WB + 1;
  localparam int unsigned CW = cnt_w(WB);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [AW-1:0] acc_q,   acc_d;
  logic [WA-1:0] ar_q,    ar_d;
  logic [PW-1:0] out_q,   out_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          last;
  logic [WA:0]   upper;
  logic [WA:0]   addend;
  logic [WA:0]   sum;
  logic [WA:0]   add_res;
  logic          sub;
  logic          cout;
  logic          ext;
  logic [AW:0]   pre;
  logic [AW-1:0] step;

  assign last  = (cnt_q == CW'(WB - 1));
  assign upper = acc_q[AW-1:WB];

`ifdef SIGNED_MULT_EN
  // The multiplier's MSB carries negative weight, so the final add becomes a subtract.
  assign addend = {ar_q[WA-1], ar_q};
  assign sub    = last & acc_q[0];
  // Shift-in is the true sign of the (WA+2)-bit sum on add steps, else plain sign extension.
  assign ext    = acc_q[0] ? (upper[WA] ^ addend[WA] ^ sub ^ cout) : acc_q[AW-1];
`else
  assign addend = {1'b0, ar_q};
  assign sub    = 1'b0;
  assign ext    = acc_q[0] & cout;
`endif

  addsub_n #(.W(WA + 1)) u_addsub (
    .x    (upper),
    .y    (addend),
    .sub  (sub),
    .s    (sum),
    .cout (cout)
  );

  // One iteration: conditional add into the upper half, then shift the whole accumulator right.
  assign add_res = acc_q[0] ? sum : upper;
  assign pre     = {ext, add_res, acc_q[WB-1:0]};
  assign step    = AW'(pre >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ar_d    = ar_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          acc_d   = {{(WA + 1){1'b0}}, bus.b};
          ar_d    = bus.a;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = step;
        if (last) begin
          state_d = ST_DONE;
          out_d   = step[PW-1:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ar_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ar_q    <= ar_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule
